// File: rtl/exmem_skid_stage.sv
// EX/MEM pipeline register with a two-entry skid buffer.
// MAIN drives the MEM-side outputs; SKID catches one extra entry so that
// InReady can be a registered signal with no combinational path from
// OutReady. Entries leave strictly in acceptance order.
module exmem_skid_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int WB_W   = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Flush,
  input  logic              InValid,
  output logic              InReady,
  input  logic [WB_W-1:0]   WB,
  input  logic [3:0]        M,
  input  logic              Zero,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] ReadData2,
  input  logic [REG_W-1:0]  WriteRegister,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [WB_W-1:0]   WBOut,
  output logic              MemReadOut,
  output logic              MemWriteOut,
  output logic              ZeroOut,
  output logic [1:0]        LoadStoreOut,
  output logic [DATA_W-1:0] ALUResultOut,
  output logic [DATA_W-1:0] ReadData2Out,
  output logic [REG_W-1:0]  WriteRegisterOut,
  output logic [1:0]        Occupancy
);

  // One pipeline entry: every field carried from EX to MEM.
  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [3:0]        m;
    logic              zero;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rd2;
    logic [REG_W-1:0]  wr;
  } entry_t;

  // Held-entry state; SKID valid without MAIN valid is never entered.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t state;
  entry_t in_entry;
  entry_t main_q;
  entry_t skid_q;
  logic   main_valid;
  logic   skid_valid;
  logic   in_ready_q;
  logic   accept;
  logic   pop;

  assign in_entry = '{wb: WB, m: M, zero: Zero, alu: ALUResult,
                      rd2: ReadData2, wr: WriteRegister};

  // Handshakes: both terms come from registers or upstream/downstream inputs,
  // never from each other, so InReady stays free of OutReady.
  assign accept = InValid && in_ready_q;
  assign pop    = main_valid && OutReady;

  // Control FSM plus MAIN entry; Flush outranks every transfer.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= S_EMPTY;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
      main_q     <= '0;
    end else if (Flush) begin
      state      <= S_EMPTY;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            main_q     <= in_entry;
            main_valid <= 1'b1;
            state      <= S_ONE;
          end
        end
        S_ONE: begin
          if (accept && pop) begin
            main_q <= in_entry;
          end else if (accept) begin
            skid_valid <= 1'b1;
            in_ready_q <= 1'b0;
            state      <= S_FULL;
          end else if (pop) begin
            main_valid <= 1'b0;
            state      <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (pop) begin
            main_q     <= skid_q;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
            state      <= S_ONE;
          end
        end
        default: begin
          state      <= S_EMPTY;
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // SKID payload captures the entry that arrives while MAIN is stalled.
  // NOTE: SKID data is deliberately not reset; it never reaches the outputs
  // and is only read when skid_valid (which is reset) says it is meaningful.
  always_ff @(posedge Clk) begin
    if (!Flush && (state == S_ONE) && accept && !pop) begin
      skid_q <= in_entry;
    end
  end

  assign InReady  = in_ready_q;
  assign OutValid = main_valid;
  assign Occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  // Control fields that would cause side effects are forced to zero in a
  // bubble; pure data fields simply keep the last MAIN contents.
  assign WBOut            = main_valid ? main_q.wb   : '0;
  assign MemReadOut       = main_valid && main_q.m[0];
  assign MemWriteOut      = main_valid && main_q.m[1];
  assign LoadStoreOut     = main_q.m[3:2];
  assign ZeroOut          = main_q.zero;
  assign ALUResultOut     = main_q.alu;
  assign ReadData2Out     = main_q.rd2;
  assign WriteRegisterOut = main_q.wr;

  // Structural invariants of the two-entry buffer.
  a_skid_implies_main : assert property (@(posedge Clk) disable iff (Rst)
    skid_valid |-> main_valid);
  a_ready_matches_state : assert property (@(posedge Clk) disable iff (Rst)
    in_ready_q == (state != S_FULL));
  a_valid_matches_state : assert property (@(posedge Clk) disable iff (Rst)
    main_valid == (state != S_EMPTY));

endmodule

// File: tb/tb_exmem_skid_stage.sv
// Self-checking bench for exmem_skid_stage: a queue-based model checked on
// every falling edge, plus directed scenarios with literal expectations.
module tb_exmem_skid_stage;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Flush;
  logic        InValid;
  logic        InReady;
  logic [1:0]  WB;
  logic [3:0]  M;
  logic        Zero;
  logic [31:0] ALUResult;
  logic [31:0] ReadData2;
  logic [4:0]  WriteRegister;
  logic        OutValid;
  logic        OutReady;
  logic [1:0]  WBOut;
  logic        MemReadOut;
  logic        MemWriteOut;
  logic        ZeroOut;
  logic [1:0]  LoadStoreOut;
  logic [31:0] ALUResultOut;
  logic [31:0] ReadData2Out;
  logic [4:0]  WriteRegisterOut;
  logic [1:0]  Occupancy;

  // Wide instance signals.
  logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [1:0]  w_wb, w_wb_out, w_ls_out;
  logic [3:0]  w_m;
  logic        w_zero, w_mr_out, w_mw_out, w_zero_out;
  logic [63:0] w_alu, w_rd2, w_alu_out, w_rd2_out;
  logic [5:0]  w_wr, w_wr_out;
  logic [1:0]  w_occ;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  exmem_skid_stage dut (
    .Clk(Clk), .Rst(Rst), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .WB(WB), .M(M), .Zero(Zero), .ALUResult(ALUResult), .ReadData2(ReadData2),
    .WriteRegister(WriteRegister), .OutValid(OutValid), .OutReady(OutReady),
    .WBOut(WBOut), .MemReadOut(MemReadOut), .MemWriteOut(MemWriteOut),
    .ZeroOut(ZeroOut), .LoadStoreOut(LoadStoreOut), .ALUResultOut(ALUResultOut),
    .ReadData2Out(ReadData2Out), .WriteRegisterOut(WriteRegisterOut),
    .Occupancy(Occupancy)
  );

  exmem_skid_stage #(.DATA_W(64), .REG_W(6), .WB_W(2)) u_wide (
    .Clk(Clk), .Rst(Rst), .Flush(1'b0), .InValid(w_in_valid), .InReady(w_in_ready),
    .WB(w_wb), .M(w_m), .Zero(w_zero), .ALUResult(w_alu), .ReadData2(w_rd2),
    .WriteRegister(w_wr), .OutValid(w_out_valid), .OutReady(w_out_ready),
    .WBOut(w_wb_out), .MemReadOut(w_mr_out), .MemWriteOut(w_mw_out),
    .ZeroOut(w_zero_out), .LoadStoreOut(w_ls_out), .ALUResultOut(w_alu_out),
    .ReadData2Out(w_rd2_out), .WriteRegisterOut(w_wr_out), .Occupancy(w_occ)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: a FIFO of capacity two ----------------
  typedef struct packed {
    logic [1:0]  wb;
    logic [3:0]  m;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [4:0]  wr;
  } ent_t;

  ent_t q[$];
  ent_t last_front = '0;

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      q.delete();
      last_front = '0;
    end else if (Flush) begin
      q.delete();
    end else begin
      bit do_pop, do_acc;
      ent_t cur;
      cur = '{wb: WB, m: M, zero: Zero, alu: ALUResult, rd2: ReadData2, wr: WriteRegister};
      do_pop = (q.size() > 0) && OutReady;
      do_acc = InValid && (q.size() < 2);
      if (do_pop) void'(q.pop_front());
      if (do_acc) q.push_back(cur);
      if (q.size() > 0) last_front = q[0];
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge Clk) begin
    bit v;
    v = (q.size() > 0);
    check("m_out_valid", 64'(OutValid), 64'(v));
    check("m_in_ready", 64'(InReady), 64'(q.size() < 2));
    check("m_occupancy", 64'(Occupancy), 64'(q.size()));
    check("m_wb", 64'(WBOut), v ? 64'(last_front.wb) : 64'd0);
    check("m_memread", 64'(MemReadOut), v ? 64'(last_front.m[0]) : 64'd0);
    check("m_memwrite", 64'(MemWriteOut), v ? 64'(last_front.m[1]) : 64'd0);
    check("m_loadstore", 64'(LoadStoreOut), 64'(last_front.m[3:2]));
    check("m_zero", 64'(ZeroOut), 64'(last_front.zero));
    check("m_alu", 64'(ALUResultOut), 64'(last_front.alu));
    check("m_rd2", 64'(ReadData2Out), 64'(last_front.rd2));
    check("m_wr", 64'(WriteRegisterOut), 64'(last_front.wr));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic [3:0] m,
                       input logic [1:0] wb, input logic rdy, input logic fl);
    InValid       = v;
    ALUResult     = alu;
    ReadData2     = alu ^ 32'hFFFF_0000;
    WriteRegister = alu[4:0];
    Zero          = (alu == 32'd0);
    M             = m;
    WB            = wb;
    OutReady      = rdy;
    Flush         = fl;
  endtask

  initial begin
    Rst = 1'b1;
    drive(1'b0, 32'd0, 4'd0, 2'd0, 1'b0, 1'b0);
    w_in_valid = 1'b0; w_out_ready = 1'b0; w_wb = '0; w_m = '0; w_zero = 1'b0;
    w_alu = '0; w_rd2 = '0; w_wr = '0;
    #2;
    check("rst_out_valid", 64'(OutValid), 64'd0);
    check("rst_in_ready", 64'(InReady), 64'd1);
    check("rst_occupancy", 64'(Occupancy), 64'd0);
    check("rst_alu", 64'(ALUResultOut), 64'd0);
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;

    // Passthrough: one entry in flight, one-cycle latency.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i * 16), 4'b0001, 2'b01, 1'b1, 1'b0);
      tick();
      check("pt_alu", 64'(ALUResultOut), 64'(i * 16));
      check("pt_occ", 64'(Occupancy), 64'd1);
    end
    drive(1'b0, 32'd0, 4'd0, 2'd0, 1'b1, 1'b0);
    tick();
    check("pt_drain_occ", 64'(Occupancy), 64'd0);

    // Backpressure: A, B held, C ignored, then in-order drain.
    drive(1'b1, 32'hA, 4'b0001, 2'b10, 1'b0, 1'b0);
    tick();
    check("bp_a_out", 64'(ALUResultOut), 64'hA);
    drive(1'b1, 32'hB, 4'b0001, 2'b10, 1'b0, 1'b0);
    tick();
    check("bp_full_occ", 64'(Occupancy), 64'd2);
    check("bp_full_ready", 64'(InReady), 64'd0);
    check("bp_hold_a", 64'(ALUResultOut), 64'hA);
    drive(1'b1, 32'hC, 4'b0001, 2'b10, 1'b0, 1'b0);
    tick();
    check("bp_c_ignored_occ", 64'(Occupancy), 64'd2);
    check("bp_still_a", 64'(ALUResultOut), 64'hA);
    drive(1'b0, 32'd0, 4'd0, 2'd0, 1'b1, 1'b0);
    tick();
    check("bp_b_out", 64'(ALUResultOut), 64'hB);
    check("bp_ready_back", 64'(InReady), 64'd1);
    check("bp_occ1", 64'(Occupancy), 64'd1);
    tick();
    check("bp_empty_valid", 64'(OutValid), 64'd0);
    check("bp_empty_hold_b", 64'(ALUResultOut), 64'hB);

    // Flush from FULL with a competing input C.
    drive(1'b1, 32'hA, 4'b0010, 2'b01, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hB, 4'b0010, 2'b01, 1'b0, 1'b0);
    tick();
    check("fl_full_occ", 64'(Occupancy), 64'd2);
    drive(1'b1, 32'hC, 4'b0010, 2'b01, 1'b0, 1'b1);
    tick();
    check("fl_valid", 64'(OutValid), 64'd0);
    check("fl_occ", 64'(Occupancy), 64'd0);
    check("fl_memwrite", 64'(MemWriteOut), 64'd0);
    check("fl_ready", 64'(InReady), 64'd1);
    drive(1'b0, 32'd0, 4'd0, 2'd0, 1'b1, 1'b0);
    repeat (3) begin
      tick();
      check("fl_c_absent", 64'(OutValid), 64'd0);
    end

    // Flush from ONE discards a same-cycle accept.
    drive(1'b1, 32'h5A, 4'b0001, 2'b01, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h5B, 4'b0001, 2'b01, 1'b1, 1'b1);
    tick();
    check("fl1_occ", 64'(Occupancy), 64'd0);
    check("fl1_valid", 64'(OutValid), 64'd0);

    // Bubble gating of side-effecting controls.
    drive(1'b1, 32'h77, 4'b1011, 2'b11, 1'b0, 1'b0);
    tick();
    check("bub_memread_on", 64'(MemReadOut), 64'd1);
    check("bub_memwrite_on", 64'(MemWriteOut), 64'd1);
    check("bub_wb_on", 64'(WBOut), 64'd3);
    drive(1'b0, 32'd0, 4'd0, 2'd0, 1'b1, 1'b0);
    tick();
    check("bub_memread", 64'(MemReadOut), 64'd0);
    check("bub_memwrite", 64'(MemWriteOut), 64'd0);
    check("bub_wb", 64'(WBOut), 64'd0);
    check("bub_loadstore", 64'(LoadStoreOut), 64'd2);

    // Mixed traffic with a flush in the middle; model checks each cycle.
    for (int i = 0; i < 48; i++) begin
      drive((i % 3) != 0, 32'h1000 + 32'(i), 4'(i) ^ 4'b0101, 2'(i),
            (i % 4) < 2 || (i % 7) == 0, i == 30);
      tick();
    end

    // Asynchronous reset while FULL.
    drive(1'b1, 32'h11, 4'b1111, 2'b11, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h22, 4'b1111, 2'b11, 1'b0, 1'b0);
    tick();
    check("ar_full_occ", 64'(Occupancy), 64'd2);
    drive(1'b0, 32'd0, 4'd0, 2'd0, 1'b0, 1'b0);
    @(negedge Clk);
    #2 Rst = 1'b1;
    #1;
    check("ar_valid", 64'(OutValid), 64'd0);
    check("ar_occ", 64'(Occupancy), 64'd0);
    check("ar_alu", 64'(ALUResultOut), 64'd0);
    check("ar_loadstore", 64'(LoadStoreOut), 64'd0);
    check("ar_ready", 64'(InReady), 64'd1);
    #1 Rst = 1'b0;
    drive(1'b1, 32'h99, 4'b0100, 2'b01, 1'b0, 1'b0);
    tick();
    check("ar_after_alu", 64'(ALUResultOut), 64'h99);
    check("ar_after_occ", 64'(Occupancy), 64'd1);
    drive(1'b0, 32'd0, 4'd0, 2'd0, 1'b1, 1'b0);
    tick();

    // Wide parameterisation passes full-width data unmodified.
    w_in_valid = 1'b1; w_out_ready = 1'b1; w_wb = 2'b01; w_m = 4'b0110;
    w_zero = 1'b1; w_alu = 64'hDEADBEEF_CAFEF00D; w_rd2 = 64'h0123_4567_89AB_CDEF;
    w_wr = 6'd63;
    tick();
    w_in_valid = 1'b0;
    check("w_valid", 64'(w_out_valid), 64'd1);
    check("w_ready", 64'(w_in_ready), 64'd1);
    check("w_occ", 64'(w_occ), 64'd1);
    check("w_alu", w_alu_out, 64'hDEADBEEF_CAFEF00D);
    check("w_rd2", w_rd2_out, 64'h0123_4567_89AB_CDEF);
    check("w_wr", 64'(w_wr_out), 64'd63);
    check("w_wb", 64'(w_wb_out), 64'd1);
    check("w_memread", 64'(w_mr_out), 64'd0);
    check("w_memwrite", 64'(w_mw_out), 64'd1);
    check("w_loadstore", 64'(w_ls_out), 64'd1);
    check("w_zero", 64'(w_zero_out), 64'd1);
    tick();
    check("w_drain_occ", 64'(w_occ), 64'd0);
    check("w_drain_wb", 64'(w_wb_out), 64'd0);

    @(posedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
